// File: rtl/fetch_pc_unit_if.sv
// Fetch request and branch-resolution bundle: master = PC unit, slave = pipeline/imem side.
interface fetch_pc_unit_if;
  logic        fetch_ready;
  logic        stall;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] pred_next_pc;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic        ex_branch_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic [31:0] ex_pred_next;
  logic        flush;

  modport master (
    input  fetch_ready, stall, ex_valid, ex_is_branch, ex_is_jump, ex_branch_taken,
           ex_pc, ex_target, ex_pred_next,
    output fetch_valid, fetch_pc, pred_next_pc, flush
  );

  modport slave (
    output fetch_ready, stall, ex_valid, ex_is_branch, ex_is_jump, ex_branch_taken,
           ex_pc, ex_target, ex_pred_next,
    input  fetch_valid, fetch_pc, pred_next_pc, flush
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC owner with BTB next-PC prediction (BTB present only when FETCH_BTB_EN is defined); redirect+flush one cycle
// after a mispredicting resolve, which overrides stall/!fetch_ready; otherwise PC advances on accept, holds on stall.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_pc_unit_if.master fe_if
);

  if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("BTB_ENTRIES must be a power of two >= 2");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word aligned");
  end

  typedef enum logic {BOOT, RUN} state_e;

  state_e      state_q;
  logic        vld_q;
  logic        flush_q, flush_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pred_next;
  logic [31:0] actual_next;
  logic        res, taken, mispredict;
  logic        unused_tgt_lo;

  assign res         = fe_if.ex_valid & (fe_if.ex_is_branch | fe_if.ex_is_jump);
  assign taken       = fe_if.ex_is_jump | fe_if.ex_branch_taken;
  assign actual_next = taken ? {fe_if.ex_target[31:2], 2'b00} : fe_if.ex_pc + 32'd4;
  assign mispredict  = res && (actual_next != fe_if.ex_pred_next);
  assign unused_tgt_lo = ^fe_if.ex_target[1:0];

  // Nothing can be in flight during BOOT, so a resolve there never redirects.
  always_comb begin
    pc_d    = pc_q;
    flush_d = 1'b0;
    if (state_q == RUN) begin
      if (mispredict) begin
        pc_d    = actual_next;
        flush_d = 1'b1;
      end else if (!fe_if.stall && fe_if.fetch_ready) begin
        pc_d = pred_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      vld_q   <= 1'b0;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          vld_q   <= 1'b1;
        end
        default: begin
          state_q <= RUN;
          vld_q   <= 1'b1;
        end
      endcase
    end
  end

  assign fe_if.fetch_valid  = vld_q;
  assign fe_if.fetch_pc     = pc_q;
  assign fe_if.pred_next_pc = pred_next;
  assign fe_if.flush        = flush_q;

`ifdef FETCH_BTB_EN
  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = 30 - IDX;

  logic [BTB_ENTRIES-1:0] btb_vld_q;
  logic [BTB_ENTRIES-1:0] btb_jmp_q;
  logic [TAGW-1:0]        btb_tag_q [BTB_ENTRIES];
  logic [29:0]            btb_tgt_q [BTB_ENTRIES];
  logic [1:0]             btb_ctr_q [BTB_ENTRIES];
  logic [IDX-1:0]         lk_idx, up_idx;
  logic                   lk_hit, up_hit;

  assign lk_idx    = pc_q[IDX+1:2];
  assign lk_hit    = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == pc_q[31:IDX+2]);
  assign pred_next = (lk_hit && (btb_jmp_q[lk_idx] || btb_ctr_q[lk_idx][1]))
                   ? {btb_tgt_q[lk_idx], 2'b00} : pc_q + 32'd4;

  assign up_idx = fe_if.ex_pc[IDX+1:2];
  assign up_hit = btb_vld_q[up_idx] && (btb_tag_q[up_idx] == fe_if.ex_pc[31:IDX+2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_vld_q <= '0;
    end else if (res && !up_hit && taken) begin
      btb_vld_q[up_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: every read is qualified by btb_vld_q.
  always_ff @(posedge clk) begin
    if (res) begin
      if (up_hit && fe_if.ex_is_jump) begin
        btb_tgt_q[up_idx] <= actual_next[31:2];
        btb_ctr_q[up_idx] <= 2'b11;
      end else if (up_hit) begin
        if (taken) begin
          btb_tgt_q[up_idx] <= actual_next[31:2];
          if (btb_ctr_q[up_idx] != 2'b11) btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] + 2'd1;
        end else if (btb_ctr_q[up_idx] != 2'b00) begin
          btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] - 2'd1;
        end
      end else if (taken) begin
        btb_tag_q[up_idx] <= fe_if.ex_pc[31:IDX+2];
        btb_tgt_q[up_idx] <= actual_next[31:2];
        btb_jmp_q[up_idx] <= fe_if.ex_is_jump;
        btb_ctr_q[up_idx] <= fe_if.ex_is_jump ? 2'b11 : 2'b10;
      end
    end
  end
`else
  assign pred_next = pc_q + 32'd4;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a reference model pushes the expected post-edge outputs, which are popped and checked after each edge.
module tb_fetch_pc_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_unit_if fif ();

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fe_if (fif)
  );

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] pred;
    logic        flush;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  logic        m_run;
  logic        m_flush;
  logic [31:0] m_pc;
`ifdef FETCH_BTB_EN
  logic        m_v   [8];
  logic [26:0] m_tag [8];
  logic [29:0] m_tgt [8];
  logic        m_j   [8];
  logic [1:0]  m_c   [8];
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_pred();
`ifdef FETCH_BTB_EN
    int i;
    i = int'(m_pc[4:2]);
    if (m_v[i] && m_tag[i] == m_pc[31:5] && (m_j[i] || m_c[i][1]))
      return {m_tgt[i], 2'b00};
`endif
    return m_pc + 32'd4;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.vld   = m_run;
    e.pc    = m_pc;
    e.pred  = m_pred();
    e.flush = m_flush;
    sb.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_vld"},   {31'd0, fif.fetch_valid}, {31'd0, e.vld});
      chk({tag, "_pc"},    fif.fetch_pc,             e.pc);
      chk({tag, "_pred"},  fif.pred_next_pc,         e.pred);
      chk({tag, "_flush"}, {31'd0, fif.flush},       {31'd0, e.flush});
    end
  endtask

`ifdef FETCH_BTB_EN
  task automatic m_btb_update(input logic tk, input logic [31:0] act);
    int   i;
    logic hit;
    i   = int'(fif.ex_pc[4:2]);
    hit = m_v[i] && (m_tag[i] == fif.ex_pc[31:5]);
    if (!hit) begin
      if (tk) begin
        m_v[i]   = 1'b1;
        m_tag[i] = fif.ex_pc[31:5];
        m_tgt[i] = act[31:2];
        m_j[i]   = fif.ex_is_jump;
        m_c[i]   = fif.ex_is_jump ? 2'd3 : 2'd2;
      end
    end else if (fif.ex_is_jump) begin
      m_tgt[i] = act[31:2];
      m_c[i]   = 2'd3;
    end else if (tk) begin
      m_tgt[i] = act[31:2];
      m_c[i]   = (m_c[i] == 2'd3) ? 2'd3 : m_c[i] + 2'd1;
    end else begin
      m_c[i]   = (m_c[i] == 2'd0) ? 2'd0 : m_c[i] - 2'd1;
    end
  endtask
`endif

  // Advance model and DUT by one clock edge, then compare.
  task automatic step(input string tag);
    logic        res, tk, mis;
    logic [31:0] act, pr;
    res = fif.ex_valid & (fif.ex_is_branch | fif.ex_is_jump);
    tk  = fif.ex_is_jump | fif.ex_branch_taken;
    act = tk ? (fif.ex_target & 32'hFFFF_FFFC) : fif.ex_pc + 32'd4;
    mis = res && (act != fif.ex_pred_next);
    pr  = m_pred();
    if (!m_run) begin
      m_run   = 1'b1;
      m_flush = 1'b0;
    end else if (mis) begin
      m_pc    = act;
      m_flush = 1'b1;
    end else begin
      m_flush = 1'b0;
      if (!fif.stall && fif.fetch_ready) m_pc = pr;
    end
`ifdef FETCH_BTB_EN
    if (res) m_btb_update(tk, act);
`endif
    push_exp();
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic ex_clear();
    fif.ex_valid        = 1'b0;
    fif.ex_is_branch    = 1'b0;
    fif.ex_is_jump      = 1'b0;
    fif.ex_branch_taken = 1'b0;
    fif.ex_pc           = 32'd0;
    fif.ex_target       = 32'd0;
    fif.ex_pred_next    = 32'd0;
  endtask

  task automatic ex_set(input logic br, input logic jmp, input logic tk,
                        input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] pred);
    fif.ex_valid        = 1'b1;
    fif.ex_is_branch    = br;
    fif.ex_is_jump      = jmp;
    fif.ex_branch_taken = tk;
    fif.ex_pc           = pc;
    fif.ex_target       = tgt;
    fif.ex_pred_next    = pred;
  endtask

  task automatic apply_reset(input string tag);
    ex_clear();
    rst_n = 1'b0;
    #2;
    m_run   = 1'b0;
    m_flush = 1'b0;
    m_pc    = 32'h0000_0000;
`ifdef FETCH_BTB_EN
    for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
`endif
    push_exp();
    compare(tag);
    @(posedge clk);
    #1;
    push_exp();
    compare({tag, "_hold"});
    rst_n = 1'b1;
  endtask

  initial begin
    fif.fetch_ready = 1'b1;
    fif.stall       = 1'b0;
    ex_clear();
    #1;
    apply_reset("rst");

    step("run0");
    step("run1");
    step("run2");

    fif.stall = 1'b1;
    repeat (3) step("stall");
    fif.stall = 1'b0;
    step("resume");
    step("to10");

    ex_set(1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 32'h14);
    step("beq_redirect");
    ex_clear();
    step("post_flush");

    ex_set(1'b0, 1'b1, 1'b0, 32'h100, 32'h10, 32'h104);
    step("jal_to10");
    ex_clear();

    // Hold at 0x10 and train its counter without redirecting.
    fif.stall = 1'b1;
    ex_set(1'b1, 1'b0, 1'b0, 32'h10, 32'h40, 32'h14);
    step("nt1");
    step("nt2");
    step("nt3_sat");
    ex_set(1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 32'h40);
    step("tk1");
    step("tk2");
    ex_clear();
    fif.stall = 1'b0;
    step("after_train");

    fif.stall       = 1'b1;
    fif.fetch_ready = 1'b0;
    ex_set(1'b1, 1'b0, 1'b1, 32'h20, 32'h83, 32'h24);
    step("misp_stalled");
    ex_clear();
    fif.stall       = 1'b0;
    fif.fetch_ready = 1'b1;
    step("after_misp");

    ex_set(1'b0, 1'b1, 1'b0, 32'h100, 32'h10, 32'h10);
    step("jal_hit");
    ex_clear();

    ex_set(1'b0, 1'b1, 1'b0, 32'h200, 32'hFFFF_FFFC, 32'h204);
    step("to_top");
    ex_clear();
    step("wrap");
    step("wrap1");

    ex_set(1'b1, 1'b0, 1'b1, 32'h0, 32'h60, 32'h4);
    step("alloc0");
    ex_clear();
    step("at60");

    apply_reset("rst_mid");
    ex_set(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0);
    step("boot_misp");
    ex_clear();
    step("after_boot");

    for (int n = 0; n < 60; n++) begin
      fif.fetch_ready = 1'($urandom_range(0, 3) != 0);
      fif.stall       = 1'($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) begin
        ex_set(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 63)) << 2, 32'($urandom_range(0, 63)) << 2, 32'd0);
        fif.ex_is_jump   = ~fif.ex_is_branch;
        fif.ex_pred_next = ($urandom_range(0, 1) != 0) ? fif.ex_pc + 32'd4 : fif.ex_target;
      end else begin
        ex_clear();
      end
      step("rand");
    end
    ex_clear();
    step("rand_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
